// File: rtl/zmod_pkg.sv
// Shared definitions for the ZMOD ADC/DAC drivers: data width, receive FSM
// states and the signed full-scale limits of a 14-bit sample.
package zmod_pkg;

  localparam int unsigned ADC_DATA_W = 14;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StRun
  } adc_state_e;

  // Two's complement full-scale limits (+8191 / -8192).
  localparam logic signed [ADC_DATA_W-1:0] AdcSatPos = 14'sh1FFF;
  localparam logic signed [ADC_DATA_W-1:0] AdcSatNeg = 14'sh2000;

  // True when a converted sample sits on either rail.
  function automatic logic is_overrange(input logic signed [ADC_DATA_W-1:0] s);
    return (s == AdcSatPos) || (s == AdcSatNeg);
  endfunction

endpackage

// File: rtl/zmod_adc_ddr_capture.sv
// DDR capture for the AD9648 multiplexed bus. Behavioural model of one
// SAME_EDGE_PIPELINED IDDR per bit (Q1 = rising/channel A, Q2 = falling/
// channel B) followed by the format register. A sample launched on rising
// edge n is on data_a_o after edge n+2, so the parent's output register
// presents it after edge n+3.
module zmod_adc_ddr_capture
  import zmod_pkg::*;
#(
  parameter bit OFFSET_BINARY = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ADC_DATA_W-1:0]        ddr_data_i,
  output logic signed [ADC_DATA_W-1:0] data_a_o,
  output logic signed [ADC_DATA_W-1:0] data_b_o
);

  // Inverting only the MSB maps offset binary onto two's complement.
  localparam logic [ADC_DATA_W-1:0] MsbFlip = {OFFSET_BINARY, {(ADC_DATA_W-1){1'b0}}};

  logic [ADC_DATA_W-1:0] rise_q, fall_q, q1_q, q2_q;
  logic [ADC_DATA_W-1:0] fmt_a_q, fmt_b_q;

  // IDDR rising-edge input register (channel A).
  always_ff @(posedge clk_i) begin
    if (rst_i) rise_q <= '0;
    else       rise_q <= ddr_data_i;
  end

  // IDDR falling-edge input register (channel B).
  always_ff @(negedge clk_i) begin
    if (rst_i) fall_q <= '0;
    else       fall_q <= ddr_data_i;
  end

  // IDDR same-edge output stage: both halves re-timed onto the rising edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= rise_q;
      q2_q <= fall_q;
    end
  end

  // Format stage: optional MSB inversion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fmt_a_q <= '0;
      fmt_b_q <= '0;
    end else begin
      fmt_a_q <= q1_q ^ MsbFlip;
      fmt_b_q <= q2_q ^ MsbFlip;
    end
  end

  assign data_a_o = fmt_a_q;
  assign data_b_o = fmt_b_q;

endmodule

// File: rtl/zmod_adc_driver.sv
// ZMOD ADC receive driver: DDR capture, pipeline flush after run, decimation
// and a one-deep valid/ready output register with saturating drop counter.
// Optional overrange flags and counter enabled by ZMOD_ADC_OVERRANGE_EN.
module zmod_adc_driver
  import zmod_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES  = 16,
  parameter bit          OFFSET_BINARY = 1'b0,
  parameter int unsigned DECIMATE      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADC_DATA_W-1:0]        is14_ddr_data,
  input  logic                         i_run,
  output logic signed [ADC_DATA_W-1:0] os14_data_a,
  output logic signed [ADC_DATA_W-1:0] os14_data_b,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_running,
  output logic [15:0]                  o16_overflow
`ifdef ZMOD_ADC_OVERRANGE_EN
  ,
  output logic                         o_ovr_a,
  output logic                         o_ovr_b,
  output logic [15:0]                  o16_ovr_count
`endif
);

  localparam logic [7:0] FlushLast = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] DecLast   = 8'(DECIMATE - 1);

  logic signed [ADC_DATA_W-1:0] cap_a, cap_b;

  adc_state_e                   state_q;
  logic [7:0]                   flush_cnt_q, dec_cnt_q;
  logic signed [ADC_DATA_W-1:0] data_a_q, data_b_q;
  logic                         valid_q, running_q;
  logic [15:0]                  ovf_q;
`ifdef ZMOD_ADC_OVERRANGE_EN
  logic                         ovr_a_q, ovr_b_q;
  logic [15:0]                  ovr_cnt_q;
`endif

  logic produce, xfer, accept;

  zmod_adc_ddr_capture #(
    .OFFSET_BINARY(OFFSET_BINARY)
  ) u_capture (
    .clk_i     (clk),
    .rst_i     (rst),
    .ddr_data_i(is14_ddr_data),
    .data_a_o  (cap_a),
    .data_b_o  (cap_b)
  );

  // Handshake decode: a pair is taken when the buffer is empty or draining.
  always_comb begin
    produce = (dec_cnt_q == 8'd0);
    xfer    = valid_q & i_ready;
    accept  = produce & (~valid_q | i_ready);
  end

  // Control FSM, decimator and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
      dec_cnt_q   <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      valid_q     <= 1'b0;
      running_q   <= 1'b0;
      ovf_q       <= '0;
`ifdef ZMOD_ADC_OVERRANGE_EN
      ovr_a_q     <= 1'b0;
      ovr_b_q     <= 1'b0;
      ovr_cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_run) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
          end
        end
        StFlush: begin
          if (!i_run) begin
            state_q <= StIdle;
          end else if (flush_cnt_q == FlushLast) begin
            state_q   <= StRun;
            dec_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 8'd1;
          end
        end
        StRun: begin
          if (!i_run) begin
            // Any pending pair is discarded, not counted as a drop.
            state_q   <= StIdle;
            valid_q   <= 1'b0;
            running_q <= 1'b0;
          end else begin
            running_q <= 1'b1;
            dec_cnt_q <= (dec_cnt_q == DecLast) ? 8'd0 : dec_cnt_q + 8'd1;
            if (accept) begin
              data_a_q <= cap_a;
              data_b_q <= cap_b;
              valid_q  <= 1'b1;
`ifdef ZMOD_ADC_OVERRANGE_EN
              ovr_a_q  <= is_overrange(cap_a);
              ovr_b_q  <= is_overrange(cap_b);
`endif
            end else if (produce) begin
              if (ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
            end else if (xfer) begin
              valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
`ifdef ZMOD_ADC_OVERRANGE_EN
      if (xfer && (ovr_a_q || ovr_b_q) && (ovr_cnt_q != 16'hFFFF)) begin
        ovr_cnt_q <= ovr_cnt_q + 16'd1;
      end
`endif
    end
  end

  assign os14_data_a  = data_a_q;
  assign os14_data_b  = data_b_q;
  assign o_valid      = valid_q;
  assign o_running    = running_q;
  assign o16_overflow = ovf_q;
`ifdef ZMOD_ADC_OVERRANGE_EN
  assign o_ovr_a       = ovr_a_q;
  assign o_ovr_b       = ovr_b_q;
  assign o16_ovr_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_zmod_adc_driver.sv
// Directed bench for zmod_adc_driver. Three instances share the inputs:
// u_dut0 (flush 4, pass-through, no decimation), u_dut1 (offset binary) and
// u_dut2 (decimate by 4). Overrange checks build with ZMOD_ADC_OVERRANGE_EN.
module tb_zmod_adc_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_run, i_ready;
  logic [13:0] bus;

  logic signed [13:0] a0, b0, a1, b1, a2, b2;
  logic               v0, v1, v2, r0, r1, r2;
  logic [15:0]        ov0, ov1, ov2;
`ifdef ZMOD_ADC_OVERRANGE_EN
  logic               oa0, ob0, oa1, ob1, oa2, ob2;
  logic [15:0]        oc0, oc1, oc2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [13:0] hist_a [0:1023];
  logic [13:0] hist_b [0:1023];

  zmod_adc_driver #(.FLUSH_CYCLES(4), .OFFSET_BINARY(1'b0), .DECIMATE(1)) u_dut0 (
    .clk(clk), .rst(rst), .is14_ddr_data(bus), .i_run(i_run),
    .os14_data_a(a0), .os14_data_b(b0), .o_valid(v0), .i_ready(i_ready),
    .o_running(r0), .o16_overflow(ov0)
`ifdef ZMOD_ADC_OVERRANGE_EN
    , .o_ovr_a(oa0), .o_ovr_b(ob0), .o16_ovr_count(oc0)
`endif
  );

  zmod_adc_driver #(.FLUSH_CYCLES(4), .OFFSET_BINARY(1'b1), .DECIMATE(1)) u_dut1 (
    .clk(clk), .rst(rst), .is14_ddr_data(bus), .i_run(i_run),
    .os14_data_a(a1), .os14_data_b(b1), .o_valid(v1), .i_ready(i_ready),
    .o_running(r1), .o16_overflow(ov1)
`ifdef ZMOD_ADC_OVERRANGE_EN
    , .o_ovr_a(oa1), .o_ovr_b(ob1), .o16_ovr_count(oc1)
`endif
  );

  zmod_adc_driver #(.FLUSH_CYCLES(4), .OFFSET_BINARY(1'b0), .DECIMATE(4)) u_dut2 (
    .clk(clk), .rst(rst), .is14_ddr_data(bus), .i_run(i_run),
    .os14_data_a(a2), .os14_data_b(b2), .o_valid(v2), .i_ready(i_ready),
    .o_running(r2), .o16_overflow(ov2)
`ifdef ZMOD_ADC_OVERRANGE_EN
    , .o_ovr_a(oa2), .o_ovr_b(ob2), .o16_ovr_count(oc2)
`endif
  );

  // One sample clock: A is on the bus at the rising edge, B at the falling
  // edge. Returns 1 ns after the rising edge; pair k shows up after edge k+3.
  task automatic step(input logic [13:0] a, input logic [13:0] b);
    @(negedge clk);
    #1 bus = a;
    hist_a[cyc] = a;
    hist_b[cyc] = b;
    @(posedge clk);
    #1 bus = b;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_run = 1'b0; i_ready = 1'b1;
    repeat (3) step(14'h0, 14'h0);
    if (v0 !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", v0); end
    n_checks++;
    if (r0 !== 1'b0) begin n_fail++; $display("FAIL rst_running: got %0b want 0", r0); end
    n_checks++;
    if (ov0 !== 16'h0) begin n_fail++; $display("FAIL rst_overflow: got %0h want 0", ov0); end
    n_checks++;
    if (a0 !== 14'h0) begin n_fail++; $display("FAIL rst_data_a: got %0h want 0", a0); end
    n_checks++;
    if (b0 !== 14'h0) begin n_fail++; $display("FAIL rst_data_b: got %0h want 0", b0); end
    n_checks++;
    rst = 1'b0;
  endtask

  // Run asserted at ramp index 2: pairs 0..3 flushed, pair 4 is first out
  // after edge 7, with o_running rising alongside.
  task automatic test_flush_and_decimate();
    logic exp_v, exp_vd;
    for (int j = 0; j < 16; j++) begin
      if (j == 2) i_run = 1'b1;
      step(14'(j), 14'(16'h1000 + j));
      exp_v  = (j >= 7);
      exp_vd = (j >= 7) && (((j - 7) % 4) == 0);
      if (v0 !== exp_v) begin
        n_fail++; $display("FAIL flush_valid[%0d]: got %0b want %0b", j, v0, exp_v);
      end
      n_checks++;
      if (r0 !== exp_v) begin
        n_fail++; $display("FAIL flush_running[%0d]: got %0b want %0b", j, r0, exp_v);
      end
      n_checks++;
      if (exp_v) begin
        if (a0 !== 14'(j - 3)) begin
          n_fail++; $display("FAIL ramp_a[%0d]: got %0h want %0h", j, a0, 14'(j - 3));
        end
        n_checks++;
        if (b0 !== 14'(16'h1000 + j - 3)) begin
          n_fail++; $display("FAIL ramp_b[%0d]: got %0h want %0h", j, b0, 14'(16'h1000 + j - 3));
        end
        n_checks++;
      end
      if (v2 !== exp_vd) begin
        n_fail++; $display("FAIL dec_valid[%0d]: got %0b want %0b", j, v2, exp_vd);
      end
      n_checks++;
      if (exp_vd) begin
        if (a2 !== 14'(j - 3)) begin
          n_fail++; $display("FAIL dec_a[%0d]: got %0h want %0h", j, a2, 14'(j - 3));
        end
        n_checks++;
      end
    end
  endtask

  // Raw 0x0000 / 0x3FFF / 0x2000 must read -8192 / +8191 / 0 in offset-binary mode.
  task automatic test_offset_binary();
    logic [13:0] va [3];
    logic [13:0] vb [3];
    logic [13:0] ea [3];
    logic [13:0] eb [3];
    va = '{14'h0000, 14'h2000, 14'h3FFF};
    vb = '{14'h3FFF, 14'h0000, 14'h2000};
    ea = '{14'h2000, 14'h0000, 14'h1FFF};
    eb = '{14'h1FFF, 14'h2000, 14'h0000};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) step(va[i], vb[i]);
      else       step(14'h0123, 14'h0456);
      if (i >= 3) begin
        if (v1 !== 1'b1) begin n_fail++; $display("FAIL ob_valid[%0d]: got %0b want 1", i, v1); end
        n_checks++;
        if (a1 !== ea[i-3]) begin
          n_fail++; $display("FAIL ob_a[%0d]: got %0h want %0h", i, a1, ea[i-3]);
        end
        n_checks++;
        if (b1 !== eb[i-3]) begin
          n_fail++; $display("FAIL ob_b[%0d]: got %0h want %0h", i, b1, eb[i-3]);
        end
        n_checks++;
        if (a0 !== va[i-3]) begin
          n_fail++; $display("FAIL pass_a[%0d]: got %0h want %0h", i, a0, va[i-3]);
        end
        n_checks++;
      end
    end
  endtask

  // Ten stalled cycles with a loaded pair: ten drops, data frozen.
  task automatic test_backpressure();
    int n, m;
    logic [13:0] held;
    step(14'(cyc), 14'(cyc + 500));
    n = cyc - 1;
    held = hist_a[n-3];
    i_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(14'(cyc), 14'(cyc + 500));
      if (v0 !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b want 1", k, v0); end
      n_checks++;
      if (a0 !== held) begin n_fail++; $display("FAIL bp_hold[%0d]: got %0h want %0h", k, a0, held); end
      n_checks++;
    end
    if (ov0 !== 16'd10) begin n_fail++; $display("FAIL bp_overflow: got %0d want 10", ov0); end
    n_checks++;
    i_ready = 1'b1;
    step(14'(cyc), 14'(cyc + 500));
    m = cyc - 1;
    if (a0 !== hist_a[m-3]) begin
      n_fail++; $display("FAIL bp_resume_a: got %0h want %0h", a0, hist_a[m-3]);
    end
    n_checks++;
    if (b0 !== hist_b[m-3]) begin
      n_fail++; $display("FAIL bp_resume_b: got %0h want %0h", b0, hist_b[m-3]);
    end
    n_checks++;
    step(14'(cyc), 14'(cyc + 500));
    if (a0 !== hist_a[m-2]) begin
      n_fail++; $display("FAIL bp_stream_a: got %0h want %0h", a0, hist_a[m-2]);
    end
    n_checks++;
    if (ov0 !== 16'd10) begin n_fail++; $display("FAIL bp_ovf_after: got %0d want 10", ov0); end
    n_checks++;
  endtask

  // Drop run in RUN with a pair on the output, then restart with a full flush.
  task automatic test_stop_restart();
    int t0;
    logic exp_v;
    if (v0 !== 1'b1) begin n_fail++; $display("FAIL stop_pre_valid: got %0b want 1", v0); end
    n_checks++;
    i_run = 1'b0;
    step(14'(cyc), 14'(cyc + 700));
    if (v0 !== 1'b0) begin n_fail++; $display("FAIL stop_valid: got %0b want 0", v0); end
    n_checks++;
    if (r0 !== 1'b0) begin n_fail++; $display("FAIL stop_running: got %0b want 0", r0); end
    n_checks++;
    step(14'(cyc), 14'(cyc + 700));
    i_run = 1'b1;
    t0 = cyc;
    for (int j = 0; j < 6; j++) begin
      step(14'(cyc), 14'(cyc + 700));
      exp_v = (j == 5);
      if (v0 !== exp_v) begin
        n_fail++; $display("FAIL restart_valid[%0d]: got %0b want %0b", j, v0, exp_v);
      end
      n_checks++;
      if (r0 !== exp_v) begin
        n_fail++; $display("FAIL restart_running[%0d]: got %0b want %0b", j, r0, exp_v);
      end
      n_checks++;
    end
    if (a0 !== hist_a[t0+2]) begin
      n_fail++; $display("FAIL restart_a: got %0h want %0h", a0, hist_a[t0+2]);
    end
    n_checks++;
    if (ov0 !== 16'd10) begin n_fail++; $display("FAIL restart_ovf: got %0d want 10", ov0); end
    n_checks++;
  endtask

  // Reset while flushing must clear every output, including held data and drops.
  task automatic test_reset_mid_flush();
    i_run = 1'b0;
    step(14'h0AAA, 14'h0555);
    i_run = 1'b1;
    step(14'h0AAA, 14'h0555);
    step(14'h0AAA, 14'h0555);
    if (r0 !== 1'b0) begin n_fail++; $display("FAIL flushing_running: got %0b want 0", r0); end
    n_checks++;
    rst = 1'b1;
    i_run = 1'b0;
    step(14'h0AAA, 14'h0555);
    if (v0 !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %0b want 0", v0); end
    n_checks++;
    if (r0 !== 1'b0) begin n_fail++; $display("FAIL mrst_running: got %0b want 0", r0); end
    n_checks++;
    if (ov0 !== 16'h0) begin n_fail++; $display("FAIL mrst_overflow: got %0d want 0", ov0); end
    n_checks++;
    if (a0 !== 14'h0) begin n_fail++; $display("FAIL mrst_data_a: got %0h want 0", a0); end
    n_checks++;
    if (b0 !== 14'h0) begin n_fail++; $display("FAIL mrst_data_b: got %0h want 0", b0); end
    n_checks++;
    rst = 1'b0;
    step(14'h0, 14'h0);
  endtask

`ifdef ZMOD_ADC_OVERRANGE_EN
  // A = 8191 (rail), B = 100: flag A only; count one per accepted pair.
  task automatic test_overrange();
    i_ready = 1'b1;
    i_run   = 1'b1;
    for (int j = 0; j < 9; j++) begin
      step(14'h1FFF, 14'd100);
      if (j == 5) begin
        if (oa0 !== 1'b1) begin n_fail++; $display("FAIL ovr_a: got %0b want 1", oa0); end
        n_checks++;
        if (ob0 !== 1'b0) begin n_fail++; $display("FAIL ovr_b: got %0b want 0", ob0); end
        n_checks++;
        if (oc0 !== 16'd0) begin n_fail++; $display("FAIL ovr_cnt0: got %0d want 0", oc0); end
        n_checks++;
        if (oa1 !== 1'b0) begin n_fail++; $display("FAIL ovr_ob_a: got %0b want 0", oa1); end
        n_checks++;
      end
      if (j == 6) begin
        if (oc0 !== 16'd1) begin n_fail++; $display("FAIL ovr_cnt1: got %0d want 1", oc0); end
        n_checks++;
      end
    end
    if (oc0 !== 16'd3) begin n_fail++; $display("FAIL ovr_cnt3: got %0d want 3", oc0); end
    n_checks++;
    if (oc1 !== 16'd0) begin n_fail++; $display("FAIL ovr_ob_cnt: got %0d want 0", oc1); end
    n_checks++;
  endtask
`endif

  initial begin
    bus = '0;
    rst = 1'b1;
    i_run = 1'b0;
    i_ready = 1'b1;
    test_reset();
    test_flush_and_decimate();
    test_offset_binary();
    test_backpressure();
    test_stop_restart();
    test_reset_mid_flush();
`ifdef ZMOD_ADC_OVERRANGE_EN
    test_overrange();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
